t_toggle_arbiter: RTL and testbench

//  Shares one bank of NBITS toggle cells between NREQ requesters.

---
 rtl/t_toggle_arbiter_pkg.sv | 9 +
 rtl/t_ff_cell.sv | 22 ++
 rtl/t_toggle_arbiter.sv | 123 ++++++++++++
 tb/tb_t_toggle_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t_toggle_arbiter_pkg.sv
// rtl/t_toggle_arbiter_pkg.sv - shared FSM state encodings for the toggle arbiter
// Contents: ST_IDLE / ST_GRANT / ST_DONE state codes used by t_toggle_arbiter.
package t_toggle_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - edge-triggered toggle cell with asynchronous active-low reset
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset, clears q
//   t     in  toggle enable, sampled on the rising edge
//   q     out cell state
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_toggle_arbiter.sv
// rtl/t_toggle_arbiter.sv - round-robin arbiter driving single-cycle toggles into a shared bank
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   freeze        blocks new grants while high (only looked at in IDLE)
//   req           per-requester toggle request, held until its ack
//   req_idx       bit index of requester i at [i*IDXW +: IDXW]
//   ack           one-cycle registered completion pulse, one-hot or zero
//   q             toggle bank state
//   busy          high whenever a transaction is in progress
//   toggle_count  number of toggles actually applied, wraps
//   idx_err       sticky flag for a granted index outside the bank
module t_toggle_arbiter
    import t_toggle_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      ack,
    output logic [NBITS-1:0]     q,
    output logic                 busy,
    output logic [CNTW-1:0]      toggle_count,
    output logic                 idx_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [IDXW-1:0] widx;
    logic [PW-1:0]   pick;
    logic [IDXW-1:0] pick_idx;
    logic [PW-1:0]   next_ptr;
    logic            in_range;
    logic [NBITS-1:0] t_vec;

    // First asserted request found when scanning upward from ptr, wrapping at NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] sel;
        logic          found;
        int            j;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(p) + k) % NREQ;
            if (!found && r[j]) begin
                sel   = PW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick     = rr_pick(req, rr_ptr);
    assign pick_idx = req_idx[int'(pick)*IDXW +: IDXW];
    assign next_ptr = PW'((int'(win) + 1) % NREQ);
    assign in_range = (int'(widx) < NBITS);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            win          <= '0;
            widx         <= '0;
            ack          <= '0;
            toggle_count <= '0;
            idx_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    if (!freeze && (|req)) begin
                        win   <= pick;
                        widx  <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // The cell flip itself happens in the bank on this same edge via t_vec.
                    ack      <= '0;
                    ack[win] <= 1'b1;
                    rr_ptr   <= next_ptr;
                    if (in_range) begin
                        toggle_count <= toggle_count + CNTW'(1);
                    end else begin
                        idx_err <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // t_vec is high only during the GRANT cycle, so each cell sees exactly one
    // qualifying edge per grant; an out-of-range index selects no cell.
    for (genvar i = 0; i < NBITS; i++) begin : g_bank
        assign t_vec[i] = (state == ST_GRANT) && in_range && (widx == IDXW'(i));

        t_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_t_toggle_arbiter.sv
// tb/tb_t_toggle_arbiter.sv - self-checking bench for t_toggle_arbiter with behavioural model
module tb_t_toggle_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int IDXW  = 3;
    localparam int CNTW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 freeze = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic [NREQ-1:0]      ack;
    logic [NBITS-1:0]     q;
    logic                 busy;
    logic [CNTW-1:0]      toggle_count;
    logic                 idx_err;

    t_toggle_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .IDXW  (IDXW),
        .CNTW  (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .req          (req),
        .req_idx      (req_idx),
        .ack          (ack),
        .q            (q),
        .busy         (busy),
        .toggle_count (toggle_count),
        .idx_err      (idx_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: a transaction occupies a fixed number of cycles after
    // the grant; the winner is the requester with the smallest forward distance
    // from the rotation pointer.
    int               m_left = 0;
    int               m_win = 0;
    int               m_idx = 0;
    int               m_ptr = 0;
    int               m_count = 0;
    logic [NBITS-1:0] m_q = '0;
    logic [NREQ-1:0]  m_ack = '0;
    logic             m_err = 1'b0;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
        int best;
        int bestd;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
                bestd = (i - ptr + NREQ) % NREQ;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic int idx_of(input int w);
        return int'(req_idx[w*IDXW +: IDXW]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_win   <= 0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_count <= 0;
            m_q     <= '0;
            m_ack   <= '0;
            m_err   <= 1'b0;
        end else if (m_left == 0) begin
            m_ack <= '0;
            if (!freeze && req != '0) begin
                m_win  <= model_pick(req, m_ptr);
                m_idx  <= idx_of(model_pick(req, m_ptr));
                m_left <= 2;
            end
        end else if (m_left == 2) begin
            if (m_idx < NBITS) begin
                m_q[m_idx] <= ~m_q[m_idx];
                m_count    <= (m_count + 1) % (1 << CNTW);
            end else begin
                m_err <= 1'b1;
            end
            m_ack  <= NREQ'(1) << m_win;
            m_ptr  <= (m_win + 1) % NREQ;
            m_left <= 1;
        end else begin
            m_ack  <= '0;
            m_left <= 0;
        end
    end

    int              checks = 0;
    int              failures = 0;
    int              ack_log[$];
    logic [NREQ-1:0] ack_seen = '0;
    bit              rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_q", 32'(q), 32'(m_q));
        check("model_ack", 32'(ack), 32'(m_ack));
        check("model_busy", 32'(busy), 32'(m_left != 0));
        check("model_count", 32'(toggle_count), 32'(m_count));
        check("model_idx_err", 32'(idx_err), 32'(m_err));
    endtask

    // One clock: requesters drop on a seen ack (and optionally raise new random
    // requests) just after the edge, then outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i]) req[i] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_idx[i*IDXW +: IDXW] = IDXW'($urandom_range(0, 7));
                    req[i] = 1'b1;
                end
            end
            freeze = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        compare_model();
        ack_seen = ack;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) ack_log.push_back(i);
        end
    endtask

    task automatic set_req(input int i, input int idx);
        req_idx[i*IDXW +: IDXW] = IDXW'(idx);
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        while (!ack_seen[i] && n < 20) begin
            tick();
            n++;
        end
        check("ack_timeout", 32'(n < 20), 32'd1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        freeze = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        ack_seen = '0;
        ack_log.delete();
    endtask

    initial begin
        // Reset state, then idle cycles.
        tick();
        tick();
        check("rst_q", 32'(q), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(toggle_count), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_q", 32'(q), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_err", 32'(idx_err), 32'h0);

        // Single requester.
        set_req(1, 3);
        wait_ack(1);
        check("single_q", 32'(q), 32'h08);
        check("single_ack", 32'(ack), 32'h2);
        check("single_count", 32'(toggle_count), 32'd1);
        tick();
        check("single_ack_fall", 32'(ack), 32'h0);
        check("single_idle", 32'(busy), 32'h0);
        set_req(1, 3);
        wait_ack(1);
        check("repeat_q", 32'(q), 32'h00);
        check("repeat_count", 32'(toggle_count), 32'd2);
        tick();

        // Full contention from reset: strict rotation, twice.
        do_reset();
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        req = '1;
        repeat (12) tick();
        check("rot1_len", 32'(ack_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) check("rot1_order", 32'(ack_log[k]), 32'(k));
        check("rot1_q", 32'(q), 32'h0F);
        check("rot1_count", 32'(toggle_count), 32'd4);
        ack_log.delete();
        req = '1;
        repeat (12) tick();
        check("rot2_len", 32'(ack_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) check("rot2_order", 32'(ack_log[k]), 32'(k));
        check("rot2_q", 32'(q), 32'h00);
        check("rot2_count", 32'(toggle_count), 32'd8);
        repeat (2) tick();

        // Freeze held in IDLE blocks grants; release grants on the next edge.
        ack_log.delete();
        freeze = 1'b1;
        set_req(2, 2);
        repeat (10) tick();
        check("freeze_no_ack", 32'(ack_log.size()), 32'd0);
        check("freeze_q", 32'(q), 32'h00);
        check("freeze_busy", 32'(busy), 32'h0);
        freeze = 1'b0;
        tick();
        check("unfreeze_grant", 32'(busy), 32'h1);
        wait_ack(2);
        check("unfreeze_ack", 32'(ack), 32'h4);
        tick();
        // Freeze raised during GRANT must not abort.
        set_req(3, 4);
        tick();
        freeze = 1'b1;
        wait_ack(3);
        check("freeze_in_grant_ack", 32'(ack), 32'h8);
        freeze = 1'b0;
        tick();
        check("freeze_q2", 32'(q), 32'h14);

        // Out-of-range indices: 7 and exactly NBITS.
        set_req(0, 7);
        wait_ack(0);
        check("oor_ack", 32'(ack), 32'h1);
        check("oor_q", 32'(q), 32'h14);
        check("oor_count", 32'(toggle_count), 32'd10);
        check("oor_err", 32'(idx_err), 32'h1);
        repeat (3) tick();
        check("oor_err_sticky", 32'(idx_err), 32'h1);
        set_req(1, 6);
        wait_ack(1);
        check("oor6_q", 32'(q), 32'h14);
        check("oor6_count", 32'(toggle_count), 32'd10);
        tick();

        // Reset while in GRANT drops the transaction.
        ack_log.delete();
        set_req(1, 5);
        tick();
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("rst_grant_q", 32'(q), 32'h0);
        check("rst_grant_ack", 32'(ack), 32'h0);
        check("rst_grant_err", 32'(idx_err), 32'h0);
        tick();
        rst_n    = 1'b1;
        ack_seen = '0;
        repeat (3) tick();
        check("rst_grant_no_ack", 32'(ack_log.size()), 32'd0);

        // Counter wrap: 17 applied toggles with a 4-bit counter leaves 1.
        for (int n = 0; n < 17; n++) begin
            set_req(n % NREQ, n % NBITS);
            wait_ack(n % NREQ);
            tick();
        end
        check("wrap_count", 32'(toggle_count), 32'd1);

        // Randomized traffic checked against the model every cycle.
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        freeze    = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
